// File: rtl/mouse_sync_pipe.sv
// Enable-gated pipeline for mouse position/buttons: clamps coordinates to the
// visible area, delays by STAGES advances, and flags button/movement events.
module mouse_sync_pipe #(
   parameter int unsigned XW     = 11,
   parameter int unsigned YW     = 11,
   parameter int unsigned NBTN   = 3,
   parameter int unsigned STAGES = 2,
   parameter int unsigned XMAX   = 799,
   parameter int unsigned YMAX   = 599
) (
   input  logic            pclk,
   input  logic            rst,
   input  logic            en,
   input  logic [XW-1:0]   xpos_in,
   input  logic [YW-1:0]   ypos_in,
   input  logic [NBTN-1:0] btn_in,
   output logic [XW-1:0]   xpos_out,
   output logic [YW-1:0]   ypos_out,
   output logic [NBTN-1:0] btn_out,
   output logic [NBTN-1:0] btn_press,
   output logic [NBTN-1:0] btn_release,
   output logic            moved,
   output logic            valid_out
);

   localparam int unsigned CW   = $clog2(STAGES + 1);
   localparam int unsigned PREV = (STAGES > 1) ? STAGES - 2 : 0;
   localparam logic [XW-1:0] XLIM = XW'(XMAX);
   localparam logic [YW-1:0] YLIM = YW'(YMAX);
   localparam logic [CW-1:0] FULL = CW'(STAGES);

   logic [XW-1:0]   x_q [STAGES];
   logic [YW-1:0]   y_q [STAGES];
   logic [NBTN-1:0] b_q [STAGES];
   logic [CW-1:0]   cnt;

   logic [XW-1:0]   x_c, next_x;
   logic [YW-1:0]   y_c, next_y;
   logic [NBTN-1:0] next_b;

   always_comb begin
      x_c = (xpos_in > XLIM) ? XLIM : xpos_in;
      y_c = (ypos_in > YLIM) ? YLIM : ypos_in;
   end

   // Value about to enter the last stage; with one stage that is the clamped input.
   always_comb begin
      next_x = (STAGES > 1) ? x_q[PREV] : x_c;
      next_y = (STAGES > 1) ? y_q[PREV] : y_c;
      next_b = (STAGES > 1) ? b_q[PREV] : btn_in;
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            x_q[k] <= '0;
            y_q[k] <= '0;
            b_q[k] <= '0;
         end
         cnt         <= '0;
         valid_out   <= 1'b0;
         btn_press   <= '0;
         btn_release <= '0;
         moved       <= 1'b0;
      end else begin
         btn_press   <= '0;
         btn_release <= '0;
         moved       <= 1'b0;
         if (en) begin
            x_q[0] <= x_c;
            y_q[0] <= y_c;
            b_q[0] <= btn_in;
            for (int unsigned k = 1; k < STAGES; k++) begin
               x_q[k] <= x_q[k-1];
               y_q[k] <= y_q[k-1];
               b_q[k] <= b_q[k-1];
            end
            if (cnt != FULL) cnt <= cnt + 1'b1;
            valid_out <= (cnt >= FULL - 1'b1);
            // Pulses use valid_out from before this edge, so the filling edge is silent.
            btn_press   <= {NBTN{valid_out}} & next_b & ~btn_out;
            btn_release <= {NBTN{valid_out}} & ~next_b & btn_out;
            moved       <= valid_out & ((next_x != xpos_out) | (next_y != ypos_out));
         end
      end
   end

   assign xpos_out = x_q[STAGES-1];
   assign ypos_out = y_q[STAGES-1];
   assign btn_out  = b_q[STAGES-1];

endmodule

// File: tb/tb_mouse_sync_pipe.sv
// Self-checking bench for mouse_sync_pipe: directed scenarios plus randomized
// traffic against a sample-history model, at depths 2 (default), 4 and 1.
module tb_mouse_sync_pipe;

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic [2:0]  b;
   } samp_t;

   logic        pclk = 1'b0;
   logic        rst  = 1'b0;
   logic        en   = 1'b0;
   logic [10:0] xpos_in = '0;
   logic [10:0] ypos_in = '0;
   logic [2:0]  btn_in  = '0;

   logic [10:0] xpos_out, ypos_out, x4, y4, x1, y1;
   logic [2:0]  btn_out, btn_press, btn_release, b4, p4, r4, b1, p1, r1;
   logic        moved, valid_out, m4, v4, m1, v1;

   int checks = 0;
   int errors = 0;

   // Model: newest captured sample at index 0, capped at the deepest instance.
   samp_t       hist[$];
   logic [2:0]  e_press, e_release;
   logic        e_moved;

   always #5 pclk = ~pclk;

   mouse_sync_pipe u_dut (
      .pclk(pclk), .rst(rst), .en(en), .xpos_in(xpos_in), .ypos_in(ypos_in), .btn_in(btn_in),
      .xpos_out(xpos_out), .ypos_out(ypos_out), .btn_out(btn_out), .btn_press(btn_press),
      .btn_release(btn_release), .moved(moved), .valid_out(valid_out)
   );

   mouse_sync_pipe #(.STAGES(4)) u_d4 (
      .pclk(pclk), .rst(rst), .en(en), .xpos_in(xpos_in), .ypos_in(ypos_in), .btn_in(btn_in),
      .xpos_out(x4), .ypos_out(y4), .btn_out(b4), .btn_press(p4),
      .btn_release(r4), .moved(m4), .valid_out(v4)
   );

   mouse_sync_pipe #(.STAGES(1)) u_d1 (
      .pclk(pclk), .rst(rst), .en(en), .xpos_in(xpos_in), .ypos_in(ypos_in), .btn_in(btn_in),
      .xpos_out(x1), .ypos_out(y1), .btn_out(b1), .btn_press(p1),
      .btn_release(r1), .moved(m1), .valid_out(v1)
   );

   function automatic samp_t out_of(input int d);
      if (hist.size() >= d) return hist[d-1];
      return '0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      e_press   = '0;
      e_release = '0;
      e_moved   = 1'b0;
   endtask

   task automatic model_edge();
      samp_t s, o_old, o_new;
      logic  v_old;
      if (!en) begin
         e_press = '0; e_release = '0; e_moved = 1'b0;
         return;
      end
      o_old = out_of(2);
      v_old = (hist.size() >= 2);
      s.x = (xpos_in > 11'd799) ? 11'd799 : xpos_in;
      s.y = (ypos_in > 11'd599) ? 11'd599 : ypos_in;
      s.b = btn_in;
      hist.push_front(s);
      if (hist.size() > 8) void'(hist.pop_back());
      o_new     = out_of(2);
      e_press   = v_old ? (o_new.b & ~o_old.b) : 3'b000;
      e_release = v_old ? (~o_new.b & o_old.b) : 3'b000;
      e_moved   = v_old && ((o_new.x != o_old.x) || (o_new.y != o_old.y));
   endtask

   task automatic check_all();
      samp_t o2, o4, o1;
      o2 = out_of(2); o4 = out_of(4); o1 = out_of(1);
      chk("xpos_out", 32'(xpos_out), 32'(o2.x));
      chk("ypos_out", 32'(ypos_out), 32'(o2.y));
      chk("btn_out", 32'(btn_out), 32'(o2.b));
      chk("btn_press", 32'(btn_press), 32'(e_press));
      chk("btn_release", 32'(btn_release), 32'(e_release));
      chk("moved", 32'(moved), 32'(e_moved));
      chk("valid_out", 32'(valid_out), 32'(hist.size() >= 2));
      chk("d4_xpos", 32'(x4), 32'(o4.x));
      chk("d4_valid", 32'(v4), 32'(hist.size() >= 4));
      chk("d1_xpos", 32'(x1), 32'(o1.x));
      chk("d1_ypos", 32'(y1), 32'(o1.y));
      chk("d1_valid", 32'(v1), 32'(hist.size() >= 1));
   endtask

   // Inputs are driven 1 time unit after an edge; checked 1 unit after the next.
   task automatic step(input logic e, input int x, input int y, input int b);
      en      = e;
      xpos_in = 11'(x);
      ypos_in = 11'(y);
      btn_in  = 3'(b);
      @(posedge pclk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      int x, y, b;
      int en_pat[6];

      model_reset();
      #12;
      check_all();
      @(posedge pclk); #1;
      rst = 1'b1;

      // Async reset mid-operation
      for (int i = 0; i < 4; i++) step(1'b1, 300, 10, 3'b010);
      chk("pre_reset_x", 32'(xpos_out), 32'd300);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("async_rst_valid", 32'(valid_out), 32'd0);
      @(negedge pclk) rst = 1'b1;

      // Latency and fill
      step(1'b1, 100, 50, 0);
      chk("fill_e0_valid", 32'(valid_out), 32'd0);
      step(1'b1, 100, 50, 0);
      chk("fill_e1_valid", 32'(valid_out), 32'd1);
      chk("fill_e1_x", 32'(xpos_out), 32'd100);
      chk("fill_e1_moved", 32'(moved), 32'd0);
      step(1'b1, 101, 50, 0);
      step(1'b1, 101, 50, 0);
      chk("move_pulse", 32'(moved), 32'd1);
      step(1'b1, 101, 50, 0);
      chk("move_cleared", 32'(moved), 32'd0);

      // Clamp and boundaries
      step(1'b1, 1500, 2047, 0);
      step(1'b1, 799, 599, 0);
      chk("clamp_x", 32'(xpos_out), 32'd799);
      chk("clamp_y", 32'(ypos_out), 32'd599);
      step(1'b1, 0, 0, 0);
      step(1'b1, 0, 0, 0);
      chk("pass_zero_x", 32'(xpos_out), 32'd0);

      // Button edges: btn1 held, then press btn0 while releasing btn1
      step(1'b1, 0, 0, 3'b010);
      step(1'b1, 0, 0, 3'b010);
      step(1'b1, 0, 0, 3'b010);
      step(1'b1, 0, 0, 3'b001);
      step(1'b1, 0, 0, 3'b001);
      chk("press0_release1", 32'({btn_press, btn_release}), 32'({3'b001, 3'b010}));
      for (int i = 0; i < 9; i++) step(1'b1, 0, 0, 3'b001);
      step(1'b1, 0, 0, 3'b000);
      step(1'b1, 0, 0, 3'b000);
      chk("release0", 32'(btn_release), 32'd1);

      // Enable gating
      en_pat = '{1, 0, 0, 1, 0, 1};
      for (int i = 0; i < 6; i++) step(1'(en_pat[i]), 200 + i, 100, 0);
      chk("gate_x", 32'(xpos_out), 32'd203);

      // Randomized traffic with occasional reset
      x = 0; y = 0; b = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            #2 rst = 1'b0;
            #1;
            model_reset();
            check_all();
            @(negedge pclk) rst = 1'b1;
         end
         if ($urandom_range(0, 1) == 0) x = $urandom_range(0, 2047);
         if ($urandom_range(0, 2) == 0) y = $urandom_range(0, 2047);
         if ($urandom_range(0, 3) == 0) b = b ^ (1 << $urandom_range(0, 2));
         step(1'($urandom_range(0, 3) != 0), x, y, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
